// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the Morning Clock 7-segment scan controller.
//   scan_state_t  : scan FSM encoding (ST_BLANK / ST_DRIVE)
//   ANODE_OFF     : all-anodes-off pattern (active-low selects, up to MAX_DIGITS)
//   slot_cycles() : clocks per digit slot
//   blink_cycles(): clocks per blink phase
//   cnt_w()       : counter width for a modulus (never below 1)
//   anode_n()     : active-low anode bit for one digit lane
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int unsigned MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  function automatic int unsigned slot_cycles(input int unsigned clk_hz,
                                              input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic int unsigned blink_cycles(input int unsigned clk_hz,
                                               input int unsigned blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lane is pulled low only when the slot is lit and this lane is selected.
  function automatic logic anode_n(input logic lit, input logic sel);
    return ~(lit & sel);
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: free-running slot divider (and blink phase divider when
// SEG7_BLINK_EN is defined).
//   Clk, Rst      : clock, synchronous active-high reset
//   slot_cnt      : position inside the current slot, 0..SLOT_CYCLES-1
//   slot_end      : high on the last cycle of every slot
//   blink_toggle  : high on the last cycle of every blink phase (SEG7_BLINK_EN)
module seg7_tick_gen
  import seg7_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 10,
`ifdef SEG7_BLINK_EN
  parameter int unsigned BLINK_CYCLES = 100,
`endif
  parameter int unsigned CW           = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  output logic [CW-1:0] slot_cnt,
  output logic          slot_end
`ifdef SEG7_BLINK_EN
  ,
  output logic          blink_toggle
`endif
);

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

  assign slot_end = (slot_cnt == SLOT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst)           slot_cnt <= '0;
    else if (slot_end) slot_cnt <= '0;
    else               slot_cnt <= slot_cnt + 1'b1;
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = cnt_w(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;

  assign blink_toggle = (blink_cnt == BLINK_LAST);

  always_ff @(posedge Clk) begin
    if (Rst)               blink_cnt <= '0;
    else if (blink_toggle) blink_cnt <= '0;
    else                   blink_cnt <= blink_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-anode
// digits sharing one 7-seg decoder. Each slot starts with BLANK_CYCLES of all
// anodes off (anti-ghost), then drives the slot's anode if enabled. Digit data
// is double-buffered: Load fills a pending buffer that is promoted to the active
// buffer only on the Frame_done cycle, so a frame is never torn.
// Optional feature macro: SEG7_BLINK_EN adds Blink_mask and a blink phase.
//   Clk, Rst     : clock, synchronous active-high reset (Rst beats Load)
//   Digits_in    : nibble i = digit i (digit 0 rightmost)
//   Dp_in        : decimal point request per digit
//   Digit_en     : per-digit light enable
//   Load         : capture Digits_in/Dp_in/Digit_en into the pending buffer
//   Blink_mask   : digits that blink, sampled live (SEG7_BLINK_EN only)
//   Digit_code   : nibble to the decoder
//   Dp_on        : decimal point for the current digit
//   Digit_sel_n  : active-low anode selects, at most one low
//   Frame_done   : 1-cycle pulse on the last cycle of the last slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_HZ     = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] Digits_in,
  input  logic [NUM_DIGITS-1:0]   Dp_in,
  input  logic [NUM_DIGITS-1:0]   Digit_en,
  input  logic                    Load,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   Blink_mask,
`endif
  output logic [3:0]              Digit_code,
  output logic                    Dp_on,
  output logic [NUM_DIGITS-1:0]   Digit_sel_n,
  output logic                    Frame_done
);

  localparam int unsigned SLOT_CYCLES = slot_cycles(CLK_HZ, SCAN_HZ);
  localparam int unsigned CW          = cnt_w(SLOT_CYCLES);
  localparam int unsigned IW          = cnt_w(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 1..%0d", MAX_DIGITS);
  end
  if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES must be below SLOT_CYCLES");
  end
  if (BLINK_HZ == 0) begin : g_bad_blink
    $error("seg7_scan_ctrl: BLINK_HZ must be nonzero");
  end

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] code;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      en;
  } frame_buf_t;

  // ---------------------------------------------------------------- timing
  logic [CW-1:0] slot_cnt;
  logic          slot_end;
`ifdef SEG7_BLINK_EN
  localparam int unsigned BLINK_CYCLES = blink_cycles(CLK_HZ, BLINK_HZ);
  logic blink_toggle;
`endif

  seg7_tick_gen #(
    .SLOT_CYCLES (SLOT_CYCLES),
`ifdef SEG7_BLINK_EN
    .BLINK_CYCLES(BLINK_CYCLES),
`endif
    .CW          (CW)
  ) u_tick (
    .Clk         (Clk),
    .Rst         (Rst),
    .slot_cnt    (slot_cnt),
    .slot_end    (slot_end)
`ifdef SEG7_BLINK_EN
    ,
    .blink_toggle(blink_toggle)
`endif
  );

  // ---------------------------------------------------------------- state
  scan_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   slot_nxt;
  logic            frame_end;
  frame_buf_t      pend_q, pend_d, act_q, act_d, load_buf;
  logic            pend_vld_q, pend_vld_d;

  assign load_buf = {Digits_in, Dp_in, Digit_en};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;

    case (state_q)
      ST_BLANK: if (BLANK_CYCLES == 0 || slot_cnt == BLANK_LAST) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_end && BLANK_CYCLES != 0)               state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    slot_nxt  = slot_end ? '0 : slot_cnt + 1'b1;
    frame_end = slot_end && (idx_q == IDX_LAST);

    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    if (Load) begin
      pend_d     = load_buf;
      pend_vld_d = 1'b1;
    end

    // Promotion at frame end; a Load in that same cycle bypasses pending.
    if (frame_end) begin
      pend_vld_d = 1'b0;
      if (Load)            act_d = load_buf;
      else if (pend_vld_q) act_d = pend_q;
    end
  end

  // ---------------------------------------------------------------- blink
  logic blink_kill;
`ifdef SEG7_BLINK_EN
  logic blink_on_q, blink_on_d;
  assign blink_on_d = blink_toggle ? ~blink_on_q : blink_on_q;
  assign blink_kill = ~blink_on_d & Blink_mask[idx_d];

  always_ff @(posedge Clk) begin
    if (Rst) blink_on_q <= 1'b1;
    else     blink_on_q <= blink_on_d;
  end
`else
  assign blink_kill = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  // Outputs are registered from next-cycle state so they line up exactly with
  // slot_cnt/idx rather than trailing them by a cycle.
  logic                  lit;
  logic [3:0]            code_d;
  logic                  dp_d;
  logic                  fd_d;
  logic [NUM_DIGITS-1:0] sel_d;

  always_comb begin
    lit    = (state_d == ST_DRIVE) && act_d.en[idx_d] && !blink_kill;
    code_d = act_d.code[idx_d];
    dp_d   = act_d.dp[idx_d];
    fd_d   = (slot_nxt == SLOT_LAST) && (idx_d == IDX_LAST);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    assign sel_d[i] = anode_n(lit, idx_d == IW'(i));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_BLANK;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      act_q       <= '0;
      Digit_sel_n <= ANODE_OFF[NUM_DIGITS-1:0];
      Digit_code  <= 4'h0;
      Dp_on       <= 1'b0;
      Frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      act_q       <= act_d;
      Digit_sel_n <= sel_d;
      Digit_code  <= code_d;
      Dp_on       <= dp_d;
      Frame_done  <= fd_d;
    end
  end

endmodule
